sram_array_1p_pipe_ext: RTL and testbench

- Parametrised single-port, write-masked SRAM behavioural model for XiangShan cache and predictor arrays.
- Successor to the fixed-size masked array models. Adds:
  - configurable depth, width and mask segmentation;
  - a 1- or 2-cycle read pipeline with a valid strobe;
  - hold-last-read-data output;
  - an optional zero-initialisation sequencer that runs after reset and gates requests through a ready signal.
- Sits beneath SRAMTemplate wrappers; one instance per array bank.

---
 rtl/sram_model_pkg.sv | 35 +++
 rtl/sram_rd_pipe.sv | 69 ++++++
 rtl/sram_array_1p_pipe_ext.sv | 158 +++++++++++++++
 tb/tb_sram_array_1p_pipe_ext.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_model_pkg.sv
// -----------------------------------------------------------------------------
// sram_model_pkg
//   Shared definitions for the single-port masked SRAM behavioural models.
//   Contents:
//     sram_state_e  - sequencer state: INIT (zeroing entries) or IDLE (serving)
//     RD_LAT_MIN/MAX - the two supported read latencies
//     seg_w()       - data bits covered by one write-mask bit
//     clog2()       - address width needed to index a given number of entries
// -----------------------------------------------------------------------------
package sram_model_pkg;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } sram_state_e;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 2;

    function automatic int unsigned seg_w(input int unsigned width,
                                          input int unsigned mask_segs);
        return width / mask_segs;
    endfunction

    // Smallest r with 2**r >= value; a single-entry array still gets one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// -----------------------------------------------------------------------------
// sram_rd_pipe
//   Read-result pipeline for the single-port SRAM model. With READ_LATENCY = 1
//   the array is looked up with the request address directly and the result
//   registered once. With READ_LATENCY = 2 the address/valid is registered
//   first, the array is looked up from that register, and the result is
//   registered again. The output data register only loads on a valid result,
//   so rdata holds the last read value between results.
//   Ports:
//     clock, reset   - clock, synchronous active-high reset
//     req_valid/addr - accepted read this cycle and its address
//     lookup_valid/addr - read that the parent must look up this cycle
//     lookup_data    - array contents at lookup_addr (zero if out of range)
//     rdata, rvalid  - read result and its one-cycle valid strobe
// -----------------------------------------------------------------------------
module sram_rd_pipe
    import sram_model_pkg::*;
#(
    parameter int unsigned WIDTH        = 516,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              lookup_valid,
    output logic [ADDR_W-1:0] lookup_addr,
    input  logic [WIDTH-1:0]  lookup_data,
    output logic [WIDTH-1:0]  rdata,
    output logic              rvalid
);

    if (READ_LATENCY == RD_LAT_MAX) begin : g_addr_stage
        logic              stage_valid_q;
        logic [ADDR_W-1:0] stage_addr_q;

        // NOTE: clocked state is always assigned with <=, so every register in
        // the design samples its inputs from before the edge, regardless of the
        // order the always blocks happen to be evaluated in.
        always_ff @(posedge clock) begin
            if (reset) begin
                stage_valid_q <= 1'b0;
                stage_addr_q  <= '0;
            end else begin
                stage_valid_q <= req_valid;
                if (req_valid) stage_addr_q <= req_addr;
            end
        end

        assign lookup_valid = stage_valid_q;
        assign lookup_addr  = stage_addr_q;
    end else begin : g_addr_direct
        assign lookup_valid = req_valid;
        assign lookup_addr  = req_addr;
    end

    // Data only loads on a result; otherwise it keeps the last read value.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= lookup_valid;
            if (lookup_valid) rdata <= lookup_data;
        end
    end

endmodule

// File: rtl/sram_array_1p_pipe_ext.sv
// -----------------------------------------------------------------------------
// sram_array_1p_pipe_ext
//   Single-port, write-masked SRAM model for cache/predictor array banks.
//   One request per cycle (read or masked write). Reads return after
//   READ_LATENCY cycles with a one-cycle RW0_rvalid; RW0_rdata holds between
//   results. With INIT_ON_RESET = 1 every entry is zeroed over DEPTH cycles
//   after reset, during which RW0_ready is low and requests are ignored.
//   Addresses >= DEPTH drop writes and read back as zero.
//   Ports:
//     clock, reset - clock, synchronous active-high reset
//     RW0_addr     - entry address
//     RW0_en       - request valid (taken only while RW0_ready is high)
//     RW0_wmode    - 1 = write, 0 = read
//     RW0_wmask    - per-segment write enables, SEG_W bits each
//     RW0_wdata    - write data
//     RW0_rdata    - read data (holds last result)
//     RW0_rvalid   - one-cycle pulse with each new read result
//     RW0_ready    - array accepts requests
// -----------------------------------------------------------------------------
module sram_array_1p_pipe_ext
    import sram_model_pkg::*;
#(
    parameter int unsigned DEPTH         = 32,
    parameter int unsigned WIDTH         = 516,
    parameter int unsigned MASK_SEGS     = 2,
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned INIT_ON_RESET = 1,
    parameter int unsigned ADDR_W        = clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    RW0_addr,
    input  logic                 RW0_en,
    input  logic                 RW0_wmode,
    input  logic [MASK_SEGS-1:0] RW0_wmask,
    input  logic [WIDTH-1:0]     RW0_wdata,
    output logic [WIDTH-1:0]     RW0_rdata,
    output logic                 RW0_rvalid,
    output logic                 RW0_ready
);

    localparam int unsigned       SEG_W     = seg_w(WIDTH, MASK_SEGS);
    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    if (DEPTH < 2) begin : g_bad_depth
        $error("sram_array_1p_pipe_ext: DEPTH must be at least 2");
    end
    if ((WIDTH % MASK_SEGS) != 0) begin : g_bad_mask
        $error("sram_array_1p_pipe_ext: WIDTH must be a multiple of MASK_SEGS");
    end
    if ((READ_LATENCY != RD_LAT_MIN) && (READ_LATENCY != RD_LAT_MAX)) begin : g_bad_lat
        $error("sram_array_1p_pipe_ext: READ_LATENCY must be 1 or 2");
    end

    // ---------------------------------------------------------------- sequencer
    sram_state_e       state_q, state_d;
    logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= (INIT_ON_RESET != 0) ? INIT : IDLE;
            init_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
        end
    end

    // NOTE: every signal written here gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        if (state_q == INIT) begin
            init_ptr_d = init_ptr_q + 1'b1;
            if (init_ptr_q == LAST_PTR) begin
                state_d    = IDLE;
                init_ptr_d = '0;
            end
        end
    end

    // Ready is forced low while reset is held, independent of the state.
    assign RW0_ready = (state_q == IDLE) && !reset;

    logic accept;
    logic addr_in_range;

    assign accept        = RW0_en && RW0_ready;
    assign addr_in_range = ({1'b0, RW0_addr} < DEPTH_EXT);

    // ---------------------------------------------------------- write port mux
    // The single write port is shared by the init sequencer (full-mask zero
    // writes) and accepted requests; the two never overlap because requests
    // are only accepted in IDLE.
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_bits;
    logic [WIDTH-1:0]  wr_data;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = RW0_addr;
        wr_bits = '0;
        wr_data = RW0_wdata;
        if (!reset && (state_q == INIT)) begin
            wr_en   = 1'b1;
            wr_addr = init_ptr_q;
            wr_bits = '1;
            wr_data = '0;
        end else if (accept && RW0_wmode && addr_in_range) begin
            wr_en = 1'b1;
            for (int i = 0; i < MASK_SEGS; i++) begin
                wr_bits[i*SEG_W +: SEG_W] = {SEG_W{RW0_wmask[i]}};
            end
        end
    end

    // ------------------------------------------------------------------ storage
    logic [WIDTH-1:0] ram [DEPTH];

    // NOTE: the array itself has no reset branch; clearing it is the init
    // sequencer's job, which keeps the storage mappable onto an SRAM macro.
    always_ff @(posedge clock) begin
        if (wr_en) ram[wr_addr] <= (ram[wr_addr] & ~wr_bits) | (wr_data & wr_bits);
    end

    // ---------------------------------------------------------------- read path
    logic              lookup_valid;
    logic [ADDR_W-1:0] lookup_addr;
    logic [WIDTH-1:0]  lookup_data;

    always_comb begin
        lookup_data = '0;
        if ({1'b0, lookup_addr} < DEPTH_EXT) lookup_data = ram[lookup_addr];
    end

    // With the 2-cycle pipeline the lookup happens one cycle after acceptance.
    // That still returns the array as it stood at acceptance: the port was busy
    // with the read in that cycle, so no write landed in between.
    sram_rd_pipe #(
        .WIDTH        (WIDTH),
        .ADDR_W       (ADDR_W),
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_pipe (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (accept && !RW0_wmode),
        .req_addr     (RW0_addr),
        .lookup_valid (lookup_valid),
        .lookup_addr  (lookup_addr),
        .lookup_data  (lookup_data),
        .rdata        (RW0_rdata),
        .rvalid       (RW0_rvalid)
    );

endmodule

// File: tb/tb_sram_array_1p_pipe_ext.sv
// -----------------------------------------------------------------------------
// tb_sram_array_1p_pipe_ext
//   Two instances share one stimulus stream:
//     dut_a - defaults (DEPTH 32, WIDTH 516, 2 mask segments, latency 1)
//     dut_b - DEPTH 20, WIDTH 64, 4 mask segments, latency 2
//   A reference model (plain arrays, a cycles-until-ready count per instance)
//   pushes expected read results into per-instance queues; negedge monitors
//   pop and compare whenever rvalid is seen, and check ready and hold.
// -----------------------------------------------------------------------------
module tb_sram_array_1p_pipe_ext;

    localparam int A_DEPTH = 32;
    localparam int A_WIDTH = 516;
    localparam int A_SEG   = 258;
    localparam int A_LAT   = 1;
    localparam int B_DEPTH = 20;
    localparam int B_WIDTH = 64;
    localparam int B_SEG   = 16;
    localparam int B_LAT   = 2;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [4:0]   addr  = '0;
    logic         en    = 1'b0;
    logic         wmode = 1'b0;
    logic [3:0]   wmask = '0;
    logic [515:0] wdata = '0;

    logic [515:0] rdata_a;
    logic         rvalid_a, ready_a;
    logic [63:0]  rdata_b;
    logic         rvalid_b, ready_b;

    always #5 clock = ~clock;

    sram_array_1p_pipe_ext dut_a (
        .clock      (clock),
        .reset      (reset),
        .RW0_addr   (addr),
        .RW0_en     (en),
        .RW0_wmode  (wmode),
        .RW0_wmask  (wmask[1:0]),
        .RW0_wdata  (wdata),
        .RW0_rdata  (rdata_a),
        .RW0_rvalid (rvalid_a),
        .RW0_ready  (ready_a)
    );

    sram_array_1p_pipe_ext #(
        .DEPTH         (B_DEPTH),
        .WIDTH         (B_WIDTH),
        .MASK_SEGS     (4),
        .READ_LATENCY  (B_LAT),
        .INIT_ON_RESET (1)
    ) dut_b (
        .clock      (clock),
        .reset      (reset),
        .RW0_addr   (addr),
        .RW0_en     (en),
        .RW0_wmode  (wmode),
        .RW0_wmask  (wmask),
        .RW0_wdata  (wdata[63:0]),
        .RW0_rdata  (rdata_b),
        .RW0_rvalid (rvalid_b),
        .RW0_ready  (ready_b)
    );

    // ----------------------------------------------------------- bookkeeping
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [515:0] act, input logic [515:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic [515:0] data;
        int           due;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    logic [515:0] mem_a [A_DEPTH];
    logic [63:0]  mem_b [B_DEPTH];
    int           left_a  = A_DEPTH;
    int           left_b  = B_DEPTH;
    int           cyc     = 0;
    bit           rst_d   = 1'b0;
    bit           started = 1'b0;
    logic [515:0] hold_a  = '0;
    logic [515:0] hold_b  = '0;

    // ------------------------------------------------------ reference model
    // At each edge: reset zeroes the model arrays and restarts the DEPTH-cycle
    // not-ready window; otherwise an accepted request updates the arrays or
    // queues the value the read must return and the cycle it is due.
    always @(posedge clock) begin
        cyc   = cyc + 1;
        rst_d = reset;
        if (reset) begin
            started = 1'b1;
            left_a  = A_DEPTH;
            left_b  = B_DEPTH;
            q_a.delete();
            q_b.delete();
            foreach (mem_a[i]) mem_a[i] = '0;
            foreach (mem_b[i]) mem_b[i] = '0;
        end else begin
            if (en && left_a == 0) begin
                if (wmode) begin
                    for (int i = 0; i < 2; i++)
                        if (wmask[i]) mem_a[addr][i*A_SEG +: A_SEG] = wdata[i*A_SEG +: A_SEG];
                end else begin
                    q_a.push_back('{data: mem_a[addr], due: cyc + A_LAT - 1});
                end
            end
            if (en && left_b == 0) begin
                if (wmode) begin
                    if (int'(addr) < B_DEPTH)
                        for (int i = 0; i < 4; i++)
                            if (wmask[i]) mem_b[addr][i*B_SEG +: B_SEG] = wdata[i*B_SEG +: B_SEG];
                end else begin
                    q_b.push_back('{data: (int'(addr) < B_DEPTH) ? 516'(mem_b[addr]) : '0,
                                    due: cyc + B_LAT - 1});
                end
            end
            if (left_a != 0) left_a--;
            if (left_b != 0) left_b--;
        end
    end

    // --------------------------------------------------------------- monitors
    always @(negedge clock) begin
        if (started) begin
            check("a_ready", ready_a, !reset && left_a == 0);
            if (rst_d) begin
                hold_a = '0;
                check("a_rvalid_in_reset", rvalid_a, 1'b0);
                check("a_rdata_in_reset", rdata_a, '0);
            end else if (rvalid_a) begin
                if (q_a.size() == 0) begin
                    check("a_unexpected_rvalid", rvalid_a, 1'b0);
                end else begin
                    exp_t e;
                    e = q_a.pop_front();
                    check("a_rdata", rdata_a, e.data);
                    check("a_rvalid_cycle", cyc, e.due);
                    hold_a = e.data;
                end
            end else begin
                check("a_rdata_hold", rdata_a, hold_a);
                if (q_a.size() != 0 && q_a[0].due <= cyc) begin
                    check("a_rvalid_missing", rvalid_a, 1'b1);
                    void'(q_a.pop_front());
                end
            end
        end
    end

    always @(negedge clock) begin
        if (started) begin
            check("b_ready", ready_b, !reset && left_b == 0);
            if (rst_d) begin
                hold_b = '0;
                check("b_rvalid_in_reset", rvalid_b, 1'b0);
                check("b_rdata_in_reset", rdata_b, '0);
            end else if (rvalid_b) begin
                if (q_b.size() == 0) begin
                    check("b_unexpected_rvalid", rvalid_b, 1'b0);
                end else begin
                    exp_t e;
                    e = q_b.pop_front();
                    check("b_rdata", rdata_b, e.data);
                    check("b_rvalid_cycle", cyc, e.due);
                    hold_b = e.data;
                end
            end else begin
                check("b_rdata_hold", rdata_b, hold_b);
                if (q_b.size() != 0 && q_b[0].due <= cyc) begin
                    check("b_rvalid_missing", rvalid_b, 1'b1);
                    void'(q_b.pop_front());
                end
            end
        end
    end

    // ----------------------------------------------------------------- driver
    function automatic logic [515:0] rand_wide();
        logic [543:0] r;
        for (int i = 0; i < 17; i++) r[i*32 +: 32] = $urandom;
        return r[515:0];
    endfunction

    task automatic drive(input logic e, input logic wm, input logic [4:0] a,
                         input logic [3:0] m, input logic [515:0] d);
        en = e; wmode = wm; addr = a; wmask = m; wdata = d;
        @(posedge clock); #1;
        en = 1'b0;
    endtask

    task automatic drive_random();
        drive($urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom_range(0, 31)),
              4'($urandom), rand_wide());
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        idle(n);
        reset = 1'b0;
    endtask

    // Issues random requests (ignored until ready) and measures the not-ready
    // window of each instance after reset release.
    task automatic wait_ready();
        int n  = 0;
        int nb = -1;
        while (!(ready_a && ready_b) && n < 200) begin
            drive_random();
            n++;
            if (ready_b && nb < 0) nb = n;
        end
        check("a_init_cycles", n, A_DEPTH);
        check("b_init_cycles", nb, B_DEPTH);
    endtask

    initial begin
        logic [515:0] ones;
        logic [515:0] a5;
        ones = '1;
        a5   = {129{4'hA}} ^ {129{4'hF}} ^ {129{4'hF}};
        for (int i = 0; i < 65; i++) a5[i*8 +: 8] = 8'hA5;

        do_reset(3);
        wait_ready();

        // Fresh array reads zero.
        drive(1, 0, 5, 4'h0, '0);
        idle(3);

        // Masked writes: low segment only, then high segment, each read back.
        drive(1, 1, 3, 4'b0001, ones);
        drive(1, 0, 3, 4'h0, '0);
        idle(2);
        drive(1, 1, 3, 4'b0010, a5);
        drive(1, 0, 3, 4'h0, '0);
        drive(1, 1, 3, 4'b0000, '0);
        drive(1, 0, 3, 4'h0, '0);
        idle(3);

        // Back-to-back reads, then hold of the last value.
        drive(1, 1, 0, 4'hF, 516'h11);
        drive(1, 1, 1, 4'hF, 516'h22);
        drive(1, 1, 2, 4'hF, 516'h33);
        drive(1, 0, 0, 4'h0, '0);
        drive(1, 0, 1, 4'h0, '0);
        drive(1, 0, 2, 4'h0, '0);
        idle(5);

        // Write immediately followed by a read of the same address.
        drive(1, 1, 7, 4'hF, 516'hDEAD);
        drive(1, 0, 7, 4'h0, '0);
        idle(3);

        // Out-of-range for dut_b (in range for dut_a); entry 19 must survive.
        drive(1, 1, 19, 4'hF, 516'h1919_1919);
        drive(1, 1, 25, 4'hF, 516'h2525_2525);
        drive(1, 0, 25, 4'h0, '0);
        drive(1, 0, 19, 4'h0, '0);
        idle(3);

        // Randomised traffic.
        repeat (400) drive_random();
        idle(4);

        // Reset with a read in flight, then reset again 10 cycles into INIT.
        drive(1, 1, 9, 4'hF, rand_wide());
        drive(1, 0, 9, 4'h0, '0);
        do_reset(1);
        idle(10);
        do_reset(2);
        wait_ready();
        for (int i = 0; i < 32; i++) drive(1, 0, 5'(i), 4'h0, '0);
        idle(5);

        check("a_queue_drained", q_a.size(), 0);
        check("b_queue_drained", q_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
